// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Read-side drain for dc_fifo. It turns the FIFO read port into a valid/ready
// stream in the read clock domain. A read is issued only when the small
// internal buffer has a free slot reserved for the word. Words in flight across
// the FIFO read latency are tracked in a 1-bit issue pipe. Every returned word
// is captured into the buffer, so downstream backpressure never drops or
// duplicates data.
//
// Parameters:
//   T        data type, must match the attached dc_fifo
//   LATENCY  FIFO read latency: 1 (OUT_REG=0) or 2 (OUT_REG=1)
//   DEPTH    internal buffer entries, LATENCY+2
//
// Ports:
//   rd_clk      clock
//   rd_rst      synchronous active-high reset
//   en          permits new FIFO reads (in-flight words still complete)
//   fifo_read   to FIFO rd_read
//   fifo_empty  from FIFO rd_empty
//   fifo_dout   from FIFO rd_dout
//   out_data    stream data
//   out_valid   stream valid
//   out_ready   stream ready
//   used        buffered word count
//   idle        buffer empty and nothing in flight
module fifo_stream_reader #(
  parameter type T = logic [15:0],
  parameter int LATENCY = 1,
  localparam int DEPTH = LATENCY + 2
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic                       en,
  output logic                       fifo_read,
  input  logic                       fifo_empty,
  input  T                           fifo_dout,
  output T                           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] used,
  output logic                       idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int UW = $clog2(DEPTH + 1);
  localparam int CW = UW + 1;

  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $fatal(1, "fifo_stream_reader: LATENCY must be 1 or 2");
  end

  logic [LATENCY-1:0] pipe_reg;
  logic [LATENCY-1:0] pipe_next;
  logic [PW-1:0]      wptr_reg;
  logic [PW-1:0]      wptr_next;
  logic [PW-1:0]      rptr_reg;
  logic [PW-1:0]      rptr_next;
  logic [UW-1:0]      used_reg;
  logic [UW-1:0]      used_next;
  logic [CW-1:0]      inflight;
  logic               capture;
  logic               pop;

  T mem [DEPTH];

  // Number of reads issued whose data has not yet been captured.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(pipe_reg[i]);
    end
  end

  // A read reserves a buffer slot at issue time, so used+inflight never
  // exceeds DEPTH. out_ready deliberately does not appear here: a pop frees a
  // slot only through used_reg, one cycle later.
  assign fifo_read = en && !fifo_empty && !rd_rst &&
                     ((CW'(used_reg) + inflight) < CW'(DEPTH));

  // Issue pipe: stage 0 takes the current read, later stages shift.
  assign pipe_next[0] = fifo_read;
  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_pipe
    assign pipe_next[gi] = pipe_reg[gi-1];
  end

  // The last pipe stage marks the cycle in which fifo_dout carries the word.
  assign capture   = pipe_reg[LATENCY-1];
  assign out_valid = (used_reg != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rptr_reg];
  assign used      = used_reg;
  assign idle      = (used_reg == '0) && (inflight == '0);

  // DEPTH is not a power of two for LATENCY=1, so pointers wrap explicitly.
  always_comb begin
    wptr_next = wptr_reg;
    rptr_next = rptr_reg;
    used_next = used_reg;
    if (capture) begin
      wptr_next = (wptr_reg == PW'(DEPTH - 1)) ? '0 : wptr_reg + PW'(1);
    end
    if (pop) begin
      rptr_next = (rptr_reg == PW'(DEPTH - 1)) ? '0 : rptr_reg + PW'(1);
    end
    case ({capture, pop})
      2'b10:   used_next = used_reg + UW'(1);
      2'b01:   used_next = used_reg - UW'(1);
      default: used_next = used_reg;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      pipe_reg <= '0;
      wptr_reg <= '0;
      rptr_reg <= '0;
      used_reg <= '0;
    end else begin
      pipe_reg <= pipe_next;
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      used_reg <= used_next;
    end
  end

  // Buffer storage has no reset; pointers and count define its contents.
  always_ff @(posedge rd_clk) begin
    if (capture && !rd_rst) begin
      mem[wptr_reg] <= fifo_dout;
    end
  end

  // The slot reservation makes an overflowing capture impossible.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
    !(capture && !pop && (used_reg == UW'(DEPTH))));

  a_no_read_empty: assert property (@(posedge rd_clk)
    !(fifo_read && fifo_empty));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//
// Bench for fifo_stream_reader with two instances: dut0 uses LATENCY=1 and
// dut1 uses LATENCY=2. Each instance is attached to a dc_fifo read-port model
// with the matching read latency. Loaded words are pushed to a per-instance
// expected queue and compared in order as the stream pops them.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_s;
  logic [1:0]       en_s;
  logic [1:0]       rdy_s;
  logic [1:0]       read_s;
  logic [1:0]       empty_s;
  logic [1:0]       valid_s;
  logic [1:0]       idle_s;
  logic [1:0][15:0] dout_s;
  logic [1:0][15:0] data_s;
  logic [1:0][2:0]  used_s;

  logic [15:0] fmem [2][2048];
  int          wr_cnt [2];
  logic [15:0] sb [2][$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = gi + 1;
    localparam int UWL = $clog2(LAT + 3);

    logic [UWL-1:0] used_loc;
    logic [15:0]    d1;
    logic [15:0]    d2;
    logic [15:0]    held;
    logic           hold_pending = 1'b0;
    logic [15:0]    exp_word;
    int             rd_cnt = 0;
    int             reads  = 0;
    int             pops   = 0;

    fifo_stream_reader #(
      .T       (logic [15:0]),
      .LATENCY (LAT)
    ) u_dut (
      .rd_clk     (clk),
      .rd_rst     (rst_s[gi]),
      .en         (en_s[gi]),
      .fifo_read  (read_s[gi]),
      .fifo_empty (empty_s[gi]),
      .fifo_dout  (dout_s[gi]),
      .out_data   (data_s[gi]),
      .out_valid  (valid_s[gi]),
      .out_ready  (rdy_s[gi]),
      .used       (used_loc),
      .idle       (idle_s[gi])
    );

    assign used_s[gi]  = 3'(used_loc);
    assign empty_s[gi] = (rd_cnt == wr_cnt[gi]);
    assign dout_s[gi]  = (LAT == 1) ? d1 : d2;

    // FIFO read port: rd_dout is valid LAT cycles after the read.
    // On reset, words already read out of the FIFO are lost.
    always @(posedge clk) begin
      if (read_s[gi]) begin
        d1     <= fmem[gi][rd_cnt[10:0]];
        rd_cnt <= rd_cnt + 1;
      end
      d2 <= d1;
      if (rst_s[gi]) begin
        while (sb[gi].size() > (wr_cnt[gi] - rd_cnt)) void'(sb[gi].pop_front());
      end
    end

    // Stream monitor, sampled mid-cycle.
    always @(negedge clk) begin
      if (read_s[gi]) reads = reads + 1;
      if (rst_s[gi]) begin
        hold_pending = 1'b0;
      end else begin
        if (empty_s[gi]) check($sformatf("d%0d_read_while_empty", gi), int'(read_s[gi]), 0);
        if (hold_pending) begin
          check($sformatf("d%0d_hold_valid", gi), int'(valid_s[gi]), 1);
          check($sformatf("d%0d_hold_data", gi), int'(data_s[gi]), int'(held));
        end
        hold_pending = 1'b0;
        if (valid_s[gi]) begin
          if (rdy_s[gi]) begin
            check($sformatf("d%0d_word_expected", gi), int'(sb[gi].size() > 0), 1);
            if (sb[gi].size() > 0) begin
              exp_word = sb[gi].pop_front();
              check($sformatf("d%0d_data", gi), int'(data_s[gi]), int'(exp_word));
              pops = pops + 1;
              $display("t=%0t dut%0d pop data=%04h exp=%04h", $time, gi, data_s[gi], exp_word);
            end
          end else begin
            hold_pending = 1'b1;
            held         = data_s[gi];
          end
        end
      end
    end
  end

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic load(input int i, input int n, input int base, input bit rnd);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      w = rnd ? 16'($urandom) : 16'(base + k);
      fmem[i][wr_cnt[i]] = w;
      sb[i].push_back(w);
      wr_cnt[i] = wr_cnt[i] + 1;
    end
  endtask

  task automatic drain(input int i, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      at_neg();
      if (sb[i].size() == 0 && idle_s[i]) done = 1'b1;
    end
    check($sformatf("d%0d_drain_done", i), int'(done), 1);
  endtask

  // Counts reads and valid cycles of instance i over a window that starts in
  // the current cycle.
  task automatic observe(input int i, input int cycles, output int n_rd, output int first_rd,
                         output int n_val, output int first_val, output int last_val);
    n_rd = 0; first_rd = -1; n_val = 0; first_val = -1; last_val = -1;
    for (int c = 0; c < cycles; c++) begin
      at_neg();
      if (read_s[i]) begin
        if (first_rd < 0) first_rd = c;
        n_rd++;
      end
      if (valid_s[i]) begin
        if (first_val < 0) first_val = c;
        last_val = c;
        n_val++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, fr, nv, fv, lv, p0, r0;
    bit done;

    rst_s     = 2'b11;
    en_s      = 2'b00;
    rdy_s     = 2'b00;
    wr_cnt[0] = 0;
    wr_cnt[1] = 0;
    at_pos();
    at_pos();
    rst_s = 2'b00;
    at_neg();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d_rst_valid", i), int'(valid_s[i]), 0);
      check($sformatf("d%0d_rst_used", i), int'(used_s[i]), 0);
      check($sformatf("d%0d_rst_idle", i), int'(idle_s[i]), 1);
    end

    // Single word, LATENCY=1.
    en_s[0]  = 1'b1;
    rdy_s[0] = 1'b1;
    at_pos();
    load(0, 1, 16'h1234, 1'b0);
    at_neg();
    check("single_read_n", int'(read_s[0]), 1);
    check("single_valid_n", int'(valid_s[0]), 0);
    at_neg();
    check("single_read_n1", int'(read_s[0]), 0);
    check("single_valid_n1", int'(valid_s[0]), 0);
    at_neg();
    check("single_valid_n2", int'(valid_s[0]), 1);
    check("single_data_n2", int'(data_s[0]), 16'h1234);
    at_neg();
    check("single_valid_n3", int'(valid_s[0]), 0);
    check("single_idle_n3", int'(idle_s[0]), 1);

    // Burst of 8, LATENCY=1.
    at_pos();
    load(0, 8, 0, 1'b0);
    observe(0, 16, nr, fr, nv, fv, lv);
    check("burst1_reads", nr, 8);
    check("burst1_first_read", fr, 0);
    check("burst1_valids", nv, 8);
    check("burst1_latency", fv - fr, 2);
    check("burst1_contiguous", lv - fv, 7);

    // Backpressure, LATENCY=1.
    at_pos();
    rdy_s[0] = 1'b0;
    load(0, 10, 16'h0100, 1'b0);
    observe(0, 8, nr, fr, nv, fv, lv);
    check("bp1_reads", nr, 3);
    check("bp1_read_stopped", int'(read_s[0]), 0);
    check("bp1_used", int'(used_s[0]), 3);
    check("bp1_data_head", int'(data_s[0]), 16'h0100);
    at_pos();
    rdy_s[0] = 1'b1;
    at_neg();
    check("bp1_no_read_at_first_pop", int'(read_s[0]), 0);
    at_neg();
    check("bp1_read_after_first_pop", int'(read_s[0]), 1);
    observe(0, 16, nr, fr, nv, fv, lv);
    check("bp1_refill_valids", nv, 8);
    check("bp1_refill_no_gap", lv - fv, 7);
    drain(0, 50);

    // LATENCY=2: burst, then backpressure.
    en_s[1]  = 1'b1;
    rdy_s[1] = 1'b1;
    at_pos();
    load(1, 8, 16'h0200, 1'b0);
    observe(1, 16, nr, fr, nv, fv, lv);
    check("burst2_reads", nr, 8);
    check("burst2_valids", nv, 8);
    check("burst2_latency", fv - fr, 3);
    check("burst2_contiguous", lv - fv, 7);
    at_pos();
    rdy_s[1] = 1'b0;
    load(1, 8, 16'h0300, 1'b0);
    observe(1, 10, nr, fr, nv, fv, lv);
    check("bp2_reads", nr, 4);
    check("bp2_used", int'(used_s[1]), 4);
    at_pos();
    rdy_s[1] = 1'b1;
    drain(1, 50);

    // en dropped one cycle after the third read.
    r0 = g_dut[0].reads;
    p0 = g_dut[0].pops;
    at_pos();
    load(0, 8, 16'h0400, 1'b0);
    at_pos();
    at_pos();
    at_pos();
    en_s[0] = 1'b0;
    repeat (12) at_neg();
    check("endrop_reads", g_dut[0].reads - r0, 3);
    check("endrop_pops", g_dut[0].pops - p0, 3);
    check("endrop_idle", int'(idle_s[0]), 1);
    check("endrop_fifo_not_empty", int'(empty_s[0]), 0);
    at_pos();
    en_s[0] = 1'b1;
    drain(0, 50);

    // Reset with used=3 and one word in flight (LATENCY=2).
    at_pos();
    rdy_s[1] = 1'b0;
    load(1, 10, 16'h0500, 1'b0);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      at_pos();
      if (used_s[1] == 3'd3) done = 1'b1;
    end
    check("rst_pre_used3", int'(used_s[1]), 3);
    check("rst_pre_not_idle", int'(idle_s[1]), 0);
    rst_s[1] = 1'b1;
    at_pos();
    at_neg();
    check("rst_read_gated", int'(read_s[1]), 0);
    at_pos();
    rst_s[1] = 1'b0;
    at_neg();
    check("rst_post_valid", int'(valid_s[1]), 0);
    check("rst_post_used", int'(used_s[1]), 0);
    check("rst_post_idle", int'(idle_s[1]), 1);
    p0 = g_dut[1].pops;
    at_pos();
    rdy_s[1] = 1'b1;
    drain(1, 50);
    check("rst_remaining_words", g_dut[1].pops - p0, 6);

    // Random out_ready over 1000 words on both instances.
    r0 = g_dut[0].pops;
    p0 = g_dut[1].pops;
    at_pos();
    load(0, 1000, 0, 1'b1);
    load(1, 1000, 0, 1'b1);
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      at_pos();
      rdy_s = 2'($urandom);
      if (sb[0].size() == 0 && sb[1].size() == 0 && idle_s[0] && idle_s[1]) done = 1'b1;
    end
    check("rand_done", int'(done), 1);
    check("rand_pops_d0", g_dut[0].pops - r0, 1000);
    check("rand_pops_d1", g_dut[1].pops - p0, 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
